// File: rtl/grid_io_param_if.sv
// Fabric-side bundle for grid_io_param: config chain, status and pin data.
// Pads and clock/reset stay plain ports on the tile.
interface grid_io_param_if #(
  parameter int unsigned NUM_IO = 4
);
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              cfg_done;
  logic              cfg_valid;
  logic              cfg_err;
  logic [NUM_IO-1:0] top_pin_outpad;
  logic [NUM_IO-1:0] top_pin_inpad;

  modport master (
    output ccff_head, ccff_en, top_pin_outpad,
    input  ccff_tail, cfg_done, cfg_valid, cfg_err, top_pin_inpad
  );

  modport slave (
    input  ccff_head, ccff_en, top_pin_outpad,
    output ccff_tail, cfg_done, cfg_valid, cfg_err, top_pin_inpad
  );
endinterface

// File: rtl/grid_io_param.sv
// Parametrised bottom IO grid tile: NUM_IO GPIO subtiles configured from a shift
// chain with atomic shadow commit. Optional parity bit: GRID_IO_CFG_PARITY_EN.
module grid_io_param #(
  parameter int unsigned NUM_IO   = 4,
  parameter int unsigned CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  grid_io_param_if.slave    io,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD
);
  localparam int unsigned CFG_LEN   = NUM_IO * CFG_BITS;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int unsigned PAR_LEN   = 1;
`else
  localparam int unsigned PAR_LEN   = 0;
`endif
  localparam int unsigned CHAIN_LEN = CFG_LEN + PAR_LEN;
  localparam int unsigned CNT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_IO-1:0]    dir_q, dir_d;
  logic [NUM_IO-1:0]    inv_q, inv_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic                 commit;
  logic                 par_ok;
`ifdef GRID_IO_CFG_PARITY_EN
  logic                 err_q, err_d;
`endif

  // Shift, count and commit; shadow only moves on the final shift of a load.
  always_comb begin
    chain_d = chain_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    commit  = 1'b0;
    par_ok  = 1'b1;
`ifdef GRID_IO_CFG_PARITY_EN
    err_d   = err_q;
`endif
    if (io.ccff_en) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], io.ccff_head};
      commit  = (cnt_q == CNT_LAST);
      cnt_d   = commit ? '0 : cnt_q + CNT_W'(1);
    end
`ifdef GRID_IO_CFG_PARITY_EN
    par_ok = ~(^chain_d);
`endif
    if (commit && par_ok) begin
      for (int unsigned i = 0; i < NUM_IO; i++) begin
        dir_d[i] = chain_d[CFG_BITS*i];
        inv_d[i] = chain_d[CFG_BITS*i + 1];
      end
      done_d  = 1'b1;
      valid_d = 1'b1;
`ifdef GRID_IO_CFG_PARITY_EN
      err_d   = 1'b0;
`endif
    end
`ifdef GRID_IO_CFG_PARITY_EN
    if (commit && !par_ok) begin
      err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain_q <= '0;
      cnt_q   <= '0;
      dir_q   <= '0;
      inv_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef GRID_IO_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
      valid_q <= valid_d;
`ifdef GRID_IO_CFG_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  assign io.ccff_tail = chain_q[CHAIN_LEN-1];
  assign io.cfg_done  = done_q;
  assign io.cfg_valid = valid_q;
`ifdef GRID_IO_CFG_PARITY_EN
  assign io.cfg_err   = err_q;
`else
  assign io.cfg_err   = 1'b0;
`endif

  logic [NUM_IO-1:0] pad_oe;
  logic [NUM_IO-1:0] pad_drv;
  logic [NUM_IO-1:0] inpad;

  // Pad behaviour decodes only from shadow state, so chain activity never reaches the pins.
  always_comb begin
    pad_oe  = '0;
    pad_drv = '0;
    inpad   = '0;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      pad_oe[i]  = valid_q & dir_q[i];
      pad_drv[i] = io.top_pin_outpad[i] ^ inv_q[i];
      inpad[i]   = (valid_q & ~dir_q[i]) ? (gfpga_pad_GPIO_PAD[i] ^ inv_q[i]) : 1'b0;
    end
  end

  assign io.top_pin_inpad = inpad;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_pad
    assign gfpga_pad_GPIO_PAD[g] = pad_oe[g] ? pad_drv[g] : 1'bz;
  end

endmodule

// File: tb/tb_grid_io_param.sv
// Directed scoreboard bench for grid_io_param (NUM_IO=4, CFG_BITS=2).
`timescale 1ns/1ps
module tb_grid_io_param;
  localparam int unsigned N = 4;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int CL = 9;
`else
  localparam int CL = 8;
`endif
  localparam logic [11:0] M_ALL  = 12'hFFF;
  localparam logic [11:0] M_CTRL = 12'hE0F;  // done/valid/err + inpad, pads ignored
  localparam logic [11:0] M_NOTL = 12'hEFF;  // everything except tail

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grid_io_param_if #(.NUM_IO(N)) bus();
  wire  [N-1:0] pad;
  logic [N-1:0] tb_oe;
  logic [N-1:0] tb_val;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  grid_io_param #(.NUM_IO(N), .CFG_BITS(2)) dut (
    .prog_clk           (clk),
    .pReset             (rst),
    .io                 (bus),
    .gfpga_pad_GPIO_PAD (pad)
  );

  int n_eval = 0;
  int n_fail = 0;
  int done_cnt = 0;
  string       tag_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] msk_q[$];

  function automatic logic [11:0] snap();
    return {bus.cfg_done, bus.cfg_valid, bus.cfg_err, bus.ccff_tail, pad, bus.top_pin_inpad};
  endfunction

  function automatic logic [11:0] ev(logic d, logic v, logic e, logic t,
                                     logic [3:0] p, logic [3:0] ip);
    return {d, v, e, t, p, ip};
  endfunction

  // Serial stream, first bit at index CL-1; parity bit leads when enabled.
  function automatic logic [8:0] stream(logic [7:0] b);
`ifdef GRID_IO_CFG_PARITY_EN
    return {^b, b};
`else
    return {1'b0, b};
`endif
  endfunction

  task automatic push(string t, logic [11:0] m, logic [11:0] e);
    tag_q.push_back(t);
    msk_q.push_back(m);
    exp_q.push_back(e & m);
  endtask

  task automatic check_now();
    string       t;
    logic [11:0] e, m, o;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      o = snap() & m;
      n_eval++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s observed=%03h expected=%03h", t, o, e);
      end
    end
  endtask

  task automatic check_int(string t, int o, int e);
    n_eval++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, o, e);
    end
  endtask

  task automatic shift_bits(logic [8:0] s, int from, int to);
    for (int k = from; k < to; k++) begin
      bus.ccff_head = s[CL-1-k];
      bus.ccff_en   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ccff_en   = 1'b0;
      bus.ccff_head = 1'bx;
      if (bus.cfg_done) done_cnt++;
    end
  endtask

  task automatic idle(int n);
    bus.ccff_en   = 1'b0;
    bus.ccff_head = 1'bx;
    repeat (n) @(negedge clk);
  endtask

  logic [8:0] s;

  initial begin
    rst = 1'b1;
    bus.ccff_en = 1'b0;
    bus.ccff_head = 1'b0;
    bus.top_pin_outpad = 4'b1011;
    tb_oe = 4'hF;
    tb_val = 4'b1010;
    repeat (2) @(negedge clk);
    push("reset_state", M_ALL, ev(0, 0, 0, 0, 4'b1010, 4'b0000));
    check_now();
    rst = 1'b0;
    tb_oe = 4'h0;
    @(negedge clk);

    // Output mode, plain polarity
    s = stream(8'h55);
    shift_bits(s, 0, CL - 1);
    push("load55_pre_commit", M_CTRL, ev(0, 0, 0, 0, 4'b0000, 4'b0000));
    check_now();
    shift_bits(s, CL - 1, CL);
    push("load55_commit", M_ALL, ev(1, 1, 0, s[CL-1], 4'b1011, 4'b0000));
    check_now();
    idle(1);
    push("load55_done_drops", M_NOTL, ev(0, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();

    // Reset mid-load after 3 shifts
    shift_bits(stream(8'hFF), 0, 3);
    push("partial_load_pads_hold", M_NOTL, ev(0, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();
    rst = 1'b1;
    #1;
    tb_oe = 4'hF;
    tb_val = 4'b0110;
    #1;
    push("midload_reset", M_ALL, ev(0, 0, 0, 0, 4'b0110, 4'b0000));
    check_now();
    @(negedge clk);
    rst = 1'b0;
    tb_oe = 4'h0;
    s = stream(8'h55);
    shift_bits(s, 0, CL - 1);
    push("post_reset_no_early_commit", M_CTRL, ev(0, 0, 0, 0, 4'b0000, 4'b0000));
    check_now();
    shift_bits(s, CL - 1, CL);
    push("post_reset_commit", M_NOTL, ev(1, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();

    // Input mode, no inversion
    s = stream(8'h00);
    shift_bits(s, 0, 4);
    bus.top_pin_outpad = 4'b0110;
    #1;
    push("load00_partial_glitchfree", M_NOTL, ev(0, 1, 0, 0, 4'b0110, 4'b0000));
    check_now();
    shift_bits(s, 4, CL);
    tb_oe = 4'hF;
    tb_val = 4'b1010;
    #1;
    push("load00_input", M_NOTL, ev(1, 1, 0, 0, 4'b1010, 4'b1010));
    check_now();

    // Inversion on subtiles 0 and 2
    s = stream(8'h22);
    shift_bits(s, 0, CL);
    push("load22_invert", M_NOTL, ev(1, 1, 0, 0, 4'b1010, 4'b1111));
    check_now();
    tb_val = 4'b0110;
    #1;
    push("load22_invert_b", M_NOTL, ev(1, 1, 0, 0, 4'b0110, 4'b0011));
    check_now();

    // Gapped load of 0xFF: 5 shifts, 3 idle cycles, rest of the bits
    tb_val = 4'b1010;
    bus.top_pin_outpad = 4'b1011;
    s = stream(8'hFF);
    shift_bits(s, 0, 5);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      push("gap_hold", M_NOTL, ev(0, 1, 0, 0, 4'b1010, 4'b1111));
      check_now();
    end
    shift_bits(s, 5, CL - 1);
    push("gap_before_last", M_ALL, ev(0, 1, 0, 0, 4'b1010, 4'b1111));
    check_now();
    tb_oe = 4'h0;
    shift_bits(s, CL - 1, CL);
    push("gap_commit_tail", M_ALL, ev(1, 1, 0, s[CL-1], 4'b0100, 4'b0000));
    check_now();
    idle(1);

    // Back-to-back loads 0xFF then 0x55
    done_cnt = 0;
    shift_bits(stream(8'hFF), 0, CL);
    push("b2b_first", M_NOTL, ev(1, 1, 0, 0, 4'b0100, 4'b0000));
    check_now();
    shift_bits(stream(8'h55), 0, CL);
    push("b2b_second", M_NOTL, ev(1, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();
    idle(2);
    if (bus.cfg_done) done_cnt++;
    check_int("b2b_done_pulses", done_cnt, 2);

`ifdef GRID_IO_CFG_PARITY_EN
    s = 9'b0_0101_0101;
    shift_bits(s, 0, CL);
    push("parity_good", M_NOTL, ev(1, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();
    s = 9'b1_0000_0000;
    shift_bits(s, 0, CL);
    push("parity_bad", M_NOTL, ev(0, 1, 1, 0, 4'b1011, 4'b0000));
    check_now();
    idle(2);
    push("parity_err_sticky", M_NOTL, ev(0, 1, 1, 0, 4'b1011, 4'b0000));
    check_now();
    shift_bits(stream(8'h55), 0, CL);
    push("parity_err_cleared", M_NOTL, ev(1, 1, 0, 0, 4'b1011, 4'b0000));
    check_now();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
